// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the usb_uart TX arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TAG  = 2'd1,
    PASS = 2'd2
  } arb_state_e;

  localparam logic [3:0] TAG_PREFIX_DEFAULT = 4'hA;

  // Tag byte layout seen by host software: prefix nibble, zero, 3-bit requester id.
  function automatic logic [7:0] tag_byte(input logic [3:0] prefix, input logic [2:0] id);
    return {prefix, 1'b0, id};
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte streams plus the usb_uart TX byte handshake.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           uart_in_data;
  logic                 uart_in_valid;
  logic                 uart_in_ready;

  modport master (
    input  req_data, req_valid, req_last, uart_in_ready,
    output req_ready, uart_in_data, uart_in_valid
  );

  modport slave (
    output req_data, req_valid, req_last, uart_in_ready,
    input  req_ready, uart_in_data, uart_in_valid
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin select: first set request scanning ptr, ptr+1, ... mod NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);
  // One extra bit so ptr + offset never overflows before the modulo fold.
  localparam int SUM_W = IDX_W + 1;
  localparam logic [SUM_W-1:0] NUM = SUM_W'(NUM_REQ);

  logic [SUM_W-1:0] sum;
  logic [IDX_W-1:0] k;

  // Scan the rotated request vector and keep only the first hit.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    sum    = '0;
    k      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + SUM_W'(i);
      if (sum >= NUM) sum = sum - NUM;
      k = sum[IDX_W-1:0];
      if (!any && req[k]) begin
        any       = 1'b1;
        idx       = k;
        onehot[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of the usb_uart TX byte pipe.
//
// state | meaning
// IDLE  | no packet in progress; pick next requester from rr_ptr
// TAG   | waiting for the output slot to emit the tag byte
// PASS  | forwarding bytes of the granted requester until 'last' or timeout
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int         NUM_REQ      = 4,
  parameter bit         TAG_EN       = 1'b1,
  parameter logic [3:0] TAG_PREFIX   = TAG_PREFIX_DEFAULT,
  parameter int         IDLE_TIMEOUT = 255
) (
  input  logic              clk_48mhz,
  input  logic              reset_n,
  uart_tx_arbiter_if.master bus,
  output logic              grant_active,
  output logic [2:0]        grant_id,
  output logic              timeout_pulse
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam bit TIMEOUT_ON = (IDLE_TIMEOUT > 0);
  localparam logic [CNT_W-1:0] CNT_TC   = (IDLE_TIMEOUT > 0) ? CNT_W'(IDLE_TIMEOUT - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   grant_id_q, grant_id_d;
  logic [NUM_REQ-1:0] grant_oh_q, grant_oh_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [7:0]         out_data_q, out_data_d;
  logic               timeout_q, timeout_d;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               gnt_valid, gnt_last;
  logic [7:0]         gnt_data;
  logic               slot_free, accept;
  logic [IDX_W-1:0]   next_ptr;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (bus.req_valid),
    .ptr    (rr_ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign slot_free         = !out_valid_q || bus.uart_in_ready;
  assign next_ptr          = (grant_id_q == LAST_IDX) ? '0 : grant_id_q + IDX_W'(1);
  assign bus.uart_in_valid = out_valid_q;
  assign bus.uart_in_data  = out_data_q;
  assign grant_active      = (state_q != IDLE);
  assign grant_id          = 3'(grant_id_q);
  assign timeout_pulse     = timeout_q;

  // Mux the granted requester's stream using the registered one-hot grant.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_last  = 1'b0;
    gnt_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh_q[i]) begin
        gnt_valid = bus.req_valid[i];
        gnt_last  = bus.req_last[i];
        gnt_data  = bus.req_data[8*i +: 8];
      end
    end
  end

  // Next-state, output-register load, idle timer and requester ready.
  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    grant_oh_d    = grant_oh_q;
    rr_ptr_d      = rr_ptr_q;
    idle_cnt_d    = idle_cnt_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    timeout_d     = 1'b0;
    accept        = 1'b0;
    bus.req_ready = '0;
    // A consumed byte frees the slot unless something below reloads it.
    if (slot_free) out_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        idle_cnt_d = '0;
        if (pick_any) begin
          grant_id_d = pick_idx;
          grant_oh_d = pick_onehot;
          state_d    = TAG_EN ? TAG : PASS;
        end
      end
      TAG: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_data_d  = tag_byte(TAG_PREFIX, 3'(grant_id_q));
          state_d     = PASS;
        end
      end
      PASS: begin
        accept        = gnt_valid && slot_free;
        bus.req_ready = grant_oh_q & {NUM_REQ{accept}};
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = gnt_data;
          idle_cnt_d  = '0;
          if (gnt_last) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end
        end else if (TIMEOUT_ON && !gnt_valid && idle_cnt_q == CNT_TC) begin
          // Requester went silent mid-packet: hand the pipe to the next one.
          state_d    = IDLE;
          rr_ptr_d   = next_ptr;
          idle_cnt_d = '0;
          timeout_d  = 1'b1;
        end else if (!gnt_valid) begin
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any byte held for usb_uart.
  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant_id_q  <= '0;
      grant_oh_q  <= '0;
      rr_ptr_q    <= '0;
      idle_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      grant_oh_q  <= grant_oh_d;
      rr_ptr_q    <= rr_ptr_d;
      idle_cnt_q  <= idle_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      timeout_q   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed packets, expected uart byte stream queued up front.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic       clk_48mhz = 1'b0;
  logic       reset_n;
  logic       grant_active;
  logic [2:0] grant_id;
  logic       timeout_pulse;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus();

  uart_tx_arbiter #(
    .NUM_REQ(N), .TAG_EN(1'b1), .TAG_PREFIX(4'hA), .IDLE_TIMEOUT(4)
  ) dut (
    .clk_48mhz     (clk_48mhz),
    .reset_n       (reset_n),
    .bus           (bus),
    .grant_active  (grant_active),
    .grant_id      (grant_id),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  // Per-requester byte stores {last, data}; head/tail indices, never wrapped.
  logic [8:0]   rmem [N][64];
  int           rhead [N];
  int           rtail [N];
  logic [N-1:0] fire;
  logic [7:0]   exp_q [$];
  int           n_checks = 0;
  int           n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input logic last);
    rmem[r][rtail[r]] = {last, d};
    rtail[r]++;
  endtask

  task automatic expect_byte(input logic [7:0] b);
    exp_q.push_back(b);
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) rhead[i] = rtail[i];
  endtask

  task automatic do_reset();
    @(negedge clk_48mhz);
    reset_n = 1'b0;
    clear_reqs();
    exp_q.delete();
    repeat (2) @(negedge clk_48mhz);
    reset_n = 1'b1;
    @(negedge clk_48mhz);
  endtask

  task automatic wait_drain(input string name);
    int  n;
    bit  busy;
    n    = 0;
    busy = 1'b1;
    while (busy && n < 400) begin
      @(negedge clk_48mhz);
      n++;
      busy = (exp_q.size() != 0);
      for (int i = 0; i < N; i++) if (rhead[i] != rtail[i]) busy = 1'b1;
    end
    chk({name, "_drained"}, 32'(busy), 32'd0);
    repeat (2) @(negedge clk_48mhz);
  endtask

  // Requester driver: retire bytes accepted at the last edge, present queue heads, note handshakes.
  initial begin
    fire          = '0;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    forever begin
      @(negedge clk_48mhz);
      #1;
      for (int i = 0; i < N; i++)
        if (fire[i] && rhead[i] != rtail[i]) rhead[i]++;
      for (int i = 0; i < N; i++) begin
        if (rhead[i] != rtail[i]) begin
          bus.req_valid[i]        = 1'b1;
          bus.req_last[i]         = rmem[i][rhead[i]][8];
          bus.req_data[8*i +: 8]  = rmem[i][rhead[i]][7:0];
        end else begin
          bus.req_valid[i]        = 1'b0;
          bus.req_last[i]         = 1'b0;
          bus.req_data[8*i +: 8]  = 8'h00;
        end
      end
      #1;
      fire = bus.req_valid & bus.req_ready;
    end
  end

  // Monitor: every byte usb_uart takes must be the next expected one.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk_48mhz);
      #3;
      if (reset_n && bus.uart_in_valid && bus.uart_in_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_uart_byte", 32'(bus.uart_in_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("uart_byte", 32'(bus.uart_in_data), 32'(e));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      rhead[i] = 0;
      rtail[i] = 0;
    end
    reset_n           = 1'b1;
    bus.uart_in_ready = 1'b1;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk_48mhz);
    #3;
    chk("rst_uart_valid",    32'(bus.uart_in_valid), 32'd0);
    chk("rst_uart_data",     32'(bus.uart_in_data),  32'd0);
    chk("rst_req_ready",     32'(bus.req_ready),     32'd0);
    chk("rst_grant_id",      32'(grant_id),          32'd0);
    chk("rst_grant_active",  32'(grant_active),      32'd0);
    chk("rst_timeout_pulse", 32'(timeout_pulse),     32'd0);
    @(negedge clk_48mhz);
    reset_n = 1'b1;

    // 1: single packet from req0 with tag
    @(negedge clk_48mhz);
    push_byte(0, 8'h11, 1'b0); push_byte(0, 8'h22, 1'b0); push_byte(0, 8'h33, 1'b1);
    expect_byte(8'hA0); expect_byte(8'h11); expect_byte(8'h22); expect_byte(8'h33);
    wait_drain("t1");
    #3 chk("t1_grant_active_after", 32'(grant_active), 32'd0);

    // 2: req1 and req3 together from reset, rr_ptr=0 -> req1 first
    do_reset();
    push_byte(1, 8'h51, 1'b1);
    push_byte(3, 8'h71, 1'b0); push_byte(3, 8'h72, 1'b1);
    expect_byte(8'hA1); expect_byte(8'h51);
    expect_byte(8'hA3); expect_byte(8'h71); expect_byte(8'h72);
    wait_drain("t2");

    // 3: all four stream one-byte packets; order 0,1,2,3,0,1,2,3
    @(negedge clk_48mhz);
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < N; i++) begin
        push_byte(i, 8'(8'h40 + 16*i + p), 1'b1);
        expect_byte(8'(8'hA0 + i));
        expect_byte(8'(8'h40 + 16*i + p));
      end
    wait_drain("t3");
    #3 chk("t3_last_grant_id", 32'(grant_id), 32'd3);

    // 4: usb_uart stalls 5 cycles while C1 is held in the output register
    @(negedge clk_48mhz);
    push_byte(2, 8'hC1, 1'b0); push_byte(2, 8'hC2, 1'b0);
    push_byte(2, 8'hC3, 1'b0); push_byte(2, 8'hC4, 1'b1);
    expect_byte(8'hA2); expect_byte(8'hC1); expect_byte(8'hC2);
    expect_byte(8'hC3); expect_byte(8'hC4);
    repeat (3) @(negedge clk_48mhz);
    bus.uart_in_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #3;
      chk("t4_stall_data",  32'(bus.uart_in_data),  32'hC1);
      chk("t4_stall_valid", 32'(bus.uart_in_valid), 32'd1);
      chk("t4_stall_ready", 32'(bus.req_ready),     32'd0);
      @(negedge clk_48mhz);
    end
    bus.uart_in_ready = 1'b1;
    wait_drain("t4");

    // 5: req2 goes silent mid-packet; timeout moves rr_ptr to 3, so req3 beats req0
    do_reset();
    push_byte(2, 8'hD1, 1'b0);
    expect_byte(8'hA2); expect_byte(8'hD1);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk_48mhz);
      if (c == 2) begin
        push_byte(3, 8'h3E, 1'b1);
        push_byte(0, 8'h0E, 1'b1);
        expect_byte(8'hA3); expect_byte(8'h3E);
        expect_byte(8'hA0); expect_byte(8'h0E);
      end
      #3;
      if (c >= 2 && c <= 6) chk("t5_losers_not_ready", 32'(bus.req_ready & 4'b1001), 32'd0);
      if (c == 6) begin
        chk("t5_pulse_before", 32'(timeout_pulse), 32'd0);
        chk("t5_active_before", 32'(grant_active), 32'd1);
      end
      if (c == 7) begin
        chk("t5_pulse", 32'(timeout_pulse), 32'd1);
        chk("t5_active_revoked", 32'(grant_active), 32'd0);
      end
      if (c == 8) begin
        chk("t5_pulse_one_cycle", 32'(timeout_pulse), 32'd0);
        chk("t5_next_grant", 32'(grant_id), 32'd3);
      end
    end
    wait_drain("t5");

    // 6: reset mid-packet drops the held byte; afterwards req0 wins over req2
    @(negedge clk_48mhz);
    push_byte(1, 8'h61, 1'b0); push_byte(1, 8'h62, 1'b0); push_byte(1, 8'h63, 1'b1);
    expect_byte(8'hA1);
    repeat (3) @(negedge clk_48mhz);
    reset_n = 1'b0;
    clear_reqs();
    #1;
    chk("t6_rst_uart_valid", 32'(bus.uart_in_valid), 32'd0);
    chk("t6_rst_active",     32'(grant_active),      32'd0);
    chk("t6_rst_req_ready",  32'(bus.req_ready),     32'd0);
    repeat (2) @(negedge clk_48mhz);
    reset_n = 1'b1;
    @(negedge clk_48mhz);
    push_byte(0, 8'h0F, 1'b1);
    push_byte(2, 8'h2F, 1'b1);
    expect_byte(8'hA0); expect_byte(8'h0F);
    expect_byte(8'hA2); expect_byte(8'h2F);
    wait_drain("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
